// File: rtl/vec_elem_sequencer_pkg.sv
// Shared types and defaults for the vector element sequencer.
// Opcode space, FSM states and the latched instruction payload.
package vec_elem_sequencer_pkg;

   localparam int unsigned DATA_WIDTH_DEF = 32;
   localparam int unsigned LANES_DEF      = 2;
   localparam int unsigned MAX_VL_DEF     = 8;
   localparam int unsigned MAX_OUT_DEF    = 4;
   localparam int unsigned OP_W           = 5;
   localparam int unsigned REG_W          = 5;

   typedef enum logic [OP_W-1:0] {
      VOP_ADD = 5'd0,
      VOP_SUB = 5'd1,
      VOP_MUL = 5'd2,
      VOP_AND = 5'd3,
      VOP_OR  = 5'd4,
      VOP_XOR = 5'd5,
      VOP_SLL = 5'd6,
      VOP_SRL = 5'd7,
      VOP_MIN = 5'd8,
      VOP_MAX = 5'd9,
      VOP_MV  = 5'd10
   } vec_op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } seq_state_e;

   typedef logic [REG_W-1:0] vreg_t;

   // Register-specifier part of an accepted instruction, held for all its groups
   typedef struct packed {
      vec_op_t op;
      vreg_t   vd;
      vreg_t   vs1;
      vreg_t   vs2;
   } vec_instr_t;

endpackage

// File: rtl/vec_elem_sequencer_outstanding_ctr.sv
// Up/down counter of issued-but-not-written-back micro-ops.
// Saturates at both 0 and MAX_OUT; simultaneous inc/dec leaves it unchanged.
module vec_elem_sequencer_outstanding_ctr
   import vec_elem_sequencer_pkg::*;
#(
   parameter  int unsigned MAX_OUT = MAX_OUT_DEF,
   localparam int unsigned CNT_W   = $clog2(MAX_OUT + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_inc,
   input  logic             i_dec,
   output logic [CNT_W-1:0] o_count,
   output logic             o_zero_next_c
);

   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] w_count_next;

   always_comb begin
      w_count_next = r_count;
      case ({i_inc, i_dec})
         2'b10: if (r_count != CNT_W'(MAX_OUT)) w_count_next = r_count + CNT_W'(1);
         2'b01: if (r_count != '0)              w_count_next = r_count - CNT_W'(1);
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_count <= '0;
      else          r_count <= w_count_next;
   end

   assign o_count       = r_count;
   assign o_zero_next_c = (w_count_next == '0);

   // A writeback with nothing outstanding is dropped; flag it in simulation
   a_no_ack_underflow : assert property (
      @(posedge i_clk) disable iff (!i_rst_n) (i_dec && !i_inc) |-> (r_count != '0));

endmodule

// File: rtl/vec_elem_sequencer.sv
// Issues one vector instruction as ceil(vl/LANES) element-group micro-ops,
// tracks their writebacks and holds fetch/decode until the instruction retires.
module vec_elem_sequencer
   import vec_elem_sequencer_pkg::*;
#(
   parameter  int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter  int unsigned LANES      = LANES_DEF,
   parameter  int unsigned MAX_VL     = MAX_VL_DEF,
   parameter  int unsigned MAX_OUT    = MAX_OUT_DEF,
   localparam int unsigned VL_W       = $clog2(MAX_VL + 1),
   localparam int unsigned EI_W       = $clog2(MAX_VL)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  vec_op_t               in_op,
   input  logic [REG_W-1:0]      in_vd,
   input  logic [REG_W-1:0]      in_vs1,
   input  logic [REG_W-1:0]      in_vs2,
   input  logic [DATA_WIDTH-1:0] in_scalar,
   input  logic [VL_W-1:0]       in_vl,
   output logic                  uop_valid,
   input  logic                  uop_ready,
   output vec_op_t               uop_op,
   output logic [REG_W-1:0]      uop_vd,
   output logic [REG_W-1:0]      uop_vs1,
   output logic [REG_W-1:0]      uop_vs2,
   output logic [DATA_WIDTH-1:0] uop_scalar,
   output logic [EI_W-1:0]       uop_eidx,
   output logic [LANES-1:0]      uop_emask,
   output logic                  uop_last,
   input  logic                  wb_ack,
   output logic                  busy,
   output logic                  stall_fetch,
   output logic                  done
);

   localparam int unsigned CMP_W = VL_W + 1;
   localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

   seq_state_e            r_state;
   seq_state_e            w_state_next;
   vec_instr_t            r_instr;
   logic [DATA_WIDTH-1:0] r_scalar;
   logic [VL_W-1:0]       r_vl;
   logic [EI_W-1:0]       r_eidx;

   logic [VL_W-1:0]       w_vl_clamp;
   logic [CNT_W-1:0]      w_out_cnt;
   logic                  w_cnt_zero_next;
   logic                  w_accept;
   logic                  w_hs;
   logic                  w_slot_free;
   logic                  w_last;
   logic [LANES-1:0]      w_emask;

   assign w_vl_clamp  = (in_vl > VL_W'(MAX_VL)) ? VL_W'(MAX_VL) : in_vl;
   assign w_accept    = in_valid && in_ready;
   assign w_hs        = uop_valid && uop_ready;
   // A writeback in the same cycle frees the slot the new issue would take
   assign w_slot_free = (w_out_cnt < CNT_W'(MAX_OUT)) || wb_ack;

   // Lane enables and last-group flag from the current group base
   always_comb begin
      w_emask = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         w_emask[i] = (CMP_W'(r_eidx) + CMP_W'(i)) < CMP_W'(r_vl);
      end
      w_last = (CMP_W'(r_eidx) + CMP_W'(LANES)) >= CMP_W'(r_vl);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) w_state_next = (w_vl_clamp == '0) ? DONE : RUN;
         end
         RUN: begin
            if (w_hs && w_last) w_state_next = DRAIN;
         end
         DRAIN: begin
            if (w_cnt_zero_next) w_state_next = DONE;
         end
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready    = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      uop_valid   = 1'b0;
      case (r_state)
         IDLE:  in_ready = 1'b1;
         RUN: begin
            busy      = 1'b1;
            uop_valid = w_slot_free;
         end
         DRAIN: busy = 1'b1;
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
      stall_fetch = busy;
   end

   // Instruction fields are captured once at accept; eidx walks the groups
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_instr  <= '0;
         r_scalar <= '0;
         r_vl     <= '0;
         r_eidx   <= '0;
      end else if (w_accept) begin
         r_instr  <= '{op: in_op, vd: in_vd, vs1: in_vs1, vs2: in_vs2};
         r_scalar <= in_scalar;
         r_vl     <= w_vl_clamp;
         r_eidx   <= '0;
      end else if (w_hs) begin
         r_eidx   <= r_eidx + EI_W'(LANES);
      end
   end

   vec_elem_sequencer_outstanding_ctr #(
      .MAX_OUT (MAX_OUT)
   ) u_out_ctr (
      .i_clk         (clk),
      .i_rst_n       (rst),
      .i_inc         (w_hs),
      .i_dec         (wb_ack),
      .o_count       (w_out_cnt),
      .o_zero_next_c (w_cnt_zero_next)
   );

   assign uop_op     = r_instr.op;
   assign uop_vd     = r_instr.vd;
   assign uop_vs1    = r_instr.vs1;
   assign uop_vs2    = r_instr.vs2;
   assign uop_scalar = r_scalar;
   assign uop_eidx   = r_eidx;
   assign uop_emask  = w_emask;
   assign uop_last   = w_last;

endmodule

// File: tb/tb_vec_elem_sequencer.sv
// Directed bench for vec_elem_sequencer: default LANES=2 instance plus a
// LANES=1 instance used to reach the outstanding-micro-op limit.
module tb_vec_elem_sequencer;
   import vec_elem_sequencer_pkg::*;

   localparam int unsigned DW   = 32;
   localparam int unsigned VL_W = 4;
   localparam int unsigned EI_W = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic            in_valid, in_ready;
   vec_op_t         in_op;
   logic [4:0]      in_vd, in_vs1, in_vs2;
   logic [DW-1:0]   in_scalar;
   logic [VL_W-1:0] in_vl;
   logic            uop_valid, uop_ready;
   vec_op_t         uop_op;
   logic [4:0]      uop_vd, uop_vs1, uop_vs2;
   logic [DW-1:0]   uop_scalar;
   logic [EI_W-1:0] uop_eidx;
   logic [1:0]      uop_emask;
   logic            uop_last, wb_ack, busy, stall_fetch, done;

   logic            b_in_valid, b_in_ready;
   vec_op_t         b_in_op;
   logic [4:0]      b_in_vd, b_in_vs1, b_in_vs2;
   logic [DW-1:0]   b_in_scalar;
   logic [VL_W-1:0] b_in_vl;
   logic            b_uop_valid, b_uop_ready;
   vec_op_t         b_uop_op;
   logic [4:0]      b_uop_vd, b_uop_vs1, b_uop_vs2;
   logic [DW-1:0]   b_uop_scalar;
   logic [EI_W-1:0] b_uop_eidx;
   logic [0:0]      b_uop_emask;
   logic            b_uop_last, b_wb_ack, b_busy, b_stall_fetch, b_done;

   vec_elem_sequencer u_dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_vd(in_vd), .in_vs1(in_vs1), .in_vs2(in_vs2),
      .in_scalar(in_scalar), .in_vl(in_vl),
      .uop_valid(uop_valid), .uop_ready(uop_ready), .uop_op(uop_op),
      .uop_vd(uop_vd), .uop_vs1(uop_vs1), .uop_vs2(uop_vs2),
      .uop_scalar(uop_scalar), .uop_eidx(uop_eidx), .uop_emask(uop_emask),
      .uop_last(uop_last), .wb_ack(wb_ack), .busy(busy),
      .stall_fetch(stall_fetch), .done(done)
   );

   vec_elem_sequencer #(.LANES(1), .MAX_VL(8), .MAX_OUT(4)) u_dut_l1 (
      .clk(clk), .rst(rst),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op(b_in_op),
      .in_vd(b_in_vd), .in_vs1(b_in_vs1), .in_vs2(b_in_vs2),
      .in_scalar(b_in_scalar), .in_vl(b_in_vl),
      .uop_valid(b_uop_valid), .uop_ready(b_uop_ready), .uop_op(b_uop_op),
      .uop_vd(b_uop_vd), .uop_vs1(b_uop_vs1), .uop_vs2(b_uop_vs2),
      .uop_scalar(b_uop_scalar), .uop_eidx(b_uop_eidx), .uop_emask(b_uop_emask),
      .uop_last(b_uop_last), .wb_ack(b_wb_ack), .busy(b_busy),
      .stall_fetch(b_stall_fetch), .done(b_done)
   );

   typedef struct {
      int cyc;
      int eidx;
      int emask;
      int last;
      int vd;
      int op;
      int sc;
   } rec_t;

   rec_t q[$];
   int   n_chk    = 0;
   int   n_bad    = 0;
   int   cyc      = 0;
   int   acc_cyc  = 0;
   int   done_cyc = -1;
   int   done_cnt = 0;
   bit   auto_ack = 1'b0;
   bit   last_hs  = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Record accepted micro-ops and done pulses of the LANES=2 instance
   always @(negedge clk) begin
      last_hs = 1'b0;
      if (rst) begin
         if (uop_valid && uop_ready) begin
            q.push_back('{cyc: cyc, eidx: int'(uop_eidx), emask: int'(uop_emask),
                          last: int'(uop_last), vd: int'(uop_vd), op: int'(uop_op),
                          sc: int'(uop_scalar)});
            last_hs = 1'b1;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (auto_ack) wb_ack = last_hs;
   endtask

   task automatic issue(input vec_op_t op, input int vd, input int vl, input logic [31:0] sc);
      q.delete();
      done_cnt  = 0;
      done_cyc  = -1;
      in_op     = op;
      in_vd     = 5'(vd);
      in_vs1    = 5'(vd + 1);
      in_vs2    = 5'(vd + 2);
      in_scalar = sc;
      in_vl     = 4'(vl);
      in_valid  = 1'b1;
      chk("in_ready_at_issue", 64'(in_ready), 64'(1));
      acc_cyc = cyc;
      step();
      in_valid = 1'b0;
   endtask

   task automatic finish_instr(input string tag, input int budget);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin
         step();
         n++;
      end
      chk({tag, "_done_pulses"}, 64'(done_cnt), 64'(1));
      chk({tag, "_in_ready_after"}, 64'(in_ready), 64'(1));
      chk({tag, "_busy_after"}, 64'(busy), 64'(0));
      chk({tag, "_done_cleared"}, 64'(done), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
      $fatal(1);
   end

   initial begin
      int c0;
      rst = 1'b0;
      in_valid = 1'b0; in_op = VOP_ADD; in_vd = '0; in_vs1 = '0; in_vs2 = '0;
      in_scalar = '0; in_vl = '0; uop_ready = 1'b1; wb_ack = 1'b0;
      b_in_valid = 1'b0; b_in_op = VOP_ADD; b_in_vd = '0; b_in_vs1 = '0; b_in_vs2 = '0;
      b_in_scalar = '0; b_in_vl = '0; b_uop_ready = 1'b1; b_wb_ack = 1'b0;
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_uop_valid", 64'(uop_valid), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_stall", 64'(stall_fetch), 64'(0));
      chk("rst_eidx", 64'(uop_eidx), 64'(0));
      chk("rst_b_in_ready", 64'(b_in_ready), 64'(1));
      step(); step();
      rst = 1'b1;
      step();
      auto_ack = 1'b1;

      // vl=8: four full groups, done two cycles after the last issue
      issue(VOP_ADD, 3, 8, 32'h1234_5678);
      finish_instr("v8", 30);
      chk("v8_count", 64'(q.size()), 64'(4));
      for (int i = 0; i < q.size(); i++) begin
         chk("v8_eidx", 64'(q[i].eidx), 64'(2 * i));
         chk("v8_emask", 64'(q[i].emask), 64'(3));
         chk("v8_last", 64'(q[i].last), 64'(i == 3));
         chk("v8_cyc", 64'(q[i].cyc), 64'(acc_cyc + 1 + i));
         chk("v8_vd", 64'(q[i].vd), 64'(3));
         chk("v8_sc", 64'(q[i].sc), 64'(32'h1234_5678));
      end
      chk("v8_done_cyc", 64'(done_cyc), 64'(acc_cyc + 6));

      // vl=5: tail group has one lane
      issue(VOP_SUB, 4, 5, 32'h0000_00A5);
      finish_instr("v5", 30);
      chk("v5_count", 64'(q.size()), 64'(3));
      for (int i = 0; i < q.size(); i++) begin
         chk("v5_eidx", 64'(q[i].eidx), 64'(2 * i));
         chk("v5_emask", 64'(q[i].emask), 64'((i == 2) ? 1 : 3));
         chk("v5_last", 64'(q[i].last), 64'(i == 2));
         chk("v5_op", 64'(q[i].op), 64'(VOP_SUB));
      end
      chk("v5_done_cyc", 64'(done_cyc), 64'(acc_cyc + 5));

      // vl=0: no groups, done at T+1, accepting again at T+2
      issue(VOP_MUL, 6, 0, 32'h0);
      finish_instr("v0", 10);
      chk("v0_count", 64'(q.size()), 64'(0));
      chk("v0_done_cyc", 64'(done_cyc), 64'(acc_cyc + 1));
      chk("v0_ready_cyc", 64'(cyc), 64'(acc_cyc + 2));

      // vl=12 clamps to 8
      issue(VOP_AND, 2, 12, 32'h0);
      finish_instr("v12", 30);
      chk("v12_count", 64'(q.size()), 64'(4));
      if (q.size() == 4) begin
         chk("v12_last_eidx", 64'(q[3].eidx), 64'(6));
         chk("v12_last_flag", 64'(q[3].last), 64'(1));
      end

      // Backpressure: three cycles of uop_ready=0 keep the group frozen
      uop_ready = 1'b0;
      issue(VOP_XOR, 9, 4, 32'hCAFE_0001);
      for (int k = 0; k < 3; k++) begin
         chk("bp_valid", 64'(uop_valid), 64'(1));
         chk("bp_eidx", 64'(uop_eidx), 64'(0));
         chk("bp_vd", 64'(uop_vd), 64'(9));
         chk("bp_vs1", 64'(uop_vs1), 64'(10));
         chk("bp_vs2", 64'(uop_vs2), 64'(11));
         chk("bp_op", 64'(uop_op), 64'(VOP_XOR));
         chk("bp_sc", 64'(uop_scalar), 64'(32'hCAFE_0001));
         chk("bp_emask", 64'(uop_emask), 64'(3));
         chk("bp_last", 64'(uop_last), 64'(0));
         chk("bp_stall", 64'(stall_fetch), 64'(1));
         step();
      end
      uop_ready = 1'b1;
      finish_instr("bp", 20);
      chk("bp_count", 64'(q.size()), 64'(2));
      if (q.size() == 2) begin
         chk("bp_first_cyc", 64'(q[0].cyc), 64'(acc_cyc + 4));
         chk("bp_second_eidx", 64'(q[1].eidx), 64'(2));
         chk("bp_second_last", 64'(q[1].last), 64'(1));
      end

      // Reset in the middle of RUN at eidx=4
      issue(VOP_OR, 5, 8, 32'h0000_0077);
      step(); step();
      chk("rst_pre_eidx", 64'(uop_eidx), 64'(4));
      auto_ack = 1'b0;
      wb_ack   = 1'b0;
      rst      = 1'b0;
      #1;
      chk("rst_mid_busy", 64'(busy), 64'(0));
      chk("rst_mid_valid", 64'(uop_valid), 64'(0));
      chk("rst_mid_ready", 64'(in_ready), 64'(1));
      chk("rst_mid_eidx", 64'(uop_eidx), 64'(0));
      chk("rst_mid_vd", 64'(uop_vd), 64'(0));
      step();
      rst = 1'b1;
      step();
      auto_ack = 1'b1;
      issue(VOP_MV, 7, 4, 32'h0000_0055);
      finish_instr("post_rst", 20);
      chk("post_rst_count", 64'(q.size()), 64'(2));
      if (q.size() == 2) begin
         chk("post_rst_eidx0", 64'(q[0].eidx), 64'(0));
         chk("post_rst_cyc0", 64'(q[0].cyc), 64'(acc_cyc + 1));
         chk("post_rst_vd", 64'(q[0].vd), 64'(7));
         chk("post_rst_eidx1", 64'(q[1].eidx), 64'(2));
      end

      // LANES=1 instance: withheld writebacks cap issue at four outstanding
      auto_ack    = 1'b0;
      wb_ack      = 1'b0;
      b_in_op     = VOP_MAX;
      b_in_vd     = 5'd20;
      b_in_vs1    = 5'd21;
      b_in_vs2    = 5'd22;
      b_in_scalar = 32'hDEAD_BEEF;
      b_in_vl     = 4'd6;
      b_in_valid  = 1'b1;
      chk("b_in_ready_at_issue", 64'(b_in_ready), 64'(1));
      c0 = cyc;
      step();
      b_in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("b_issue_valid", 64'(b_uop_valid), 64'(1));
         chk("b_issue_eidx", 64'(b_uop_eidx), 64'(k));
         step();
      end
      chk("b_cap_cyc", 64'(cyc), 64'(c0 + 5));
      chk("b_cap_valid", 64'(b_uop_valid), 64'(0));
      chk("b_cap_eidx", 64'(b_uop_eidx), 64'(4));
      chk("b_cap_busy", 64'(b_busy), 64'(1));
      chk("b_cap_stall", 64'(b_stall_fetch), 64'(1));
      chk("b_cap_emask", 64'(b_uop_emask), 64'(1));
      chk("b_cap_last", 64'(b_uop_last), 64'(0));
      chk("b_cap_op", 64'(b_uop_op), 64'(VOP_MAX));
      chk("b_cap_vd", 64'(b_uop_vd), 64'(20));
      chk("b_cap_vs1", 64'(b_uop_vs1), 64'(21));
      chk("b_cap_vs2", 64'(b_uop_vs2), 64'(22));
      chk("b_cap_sc", 64'(b_uop_scalar), 64'(32'hDEAD_BEEF));
      b_wb_ack = 1'b1;
      #1;
      chk("b_ack_reopens", 64'(b_uop_valid), 64'(1));
      step();
      b_wb_ack = 1'b0;
      #1;
      chk("b_count_held", 64'(b_uop_valid), 64'(0));
      chk("b_held_eidx", 64'(b_uop_eidx), 64'(5));
      chk("b_held_last", 64'(b_uop_last), 64'(1));
      b_wb_ack = 1'b1;
      step();
      chk("b_drain_valid", 64'(b_uop_valid), 64'(0));
      chk("b_drain_busy", 64'(b_busy), 64'(1));
      chk("b_drain_done", 64'(b_done), 64'(0));
      for (int k = 0; k < 4; k++) step();
      b_wb_ack = 1'b0;
      #1;
      chk("b_done_pulse", 64'(b_done), 64'(1));
      step();
      chk("b_done_cleared", 64'(b_done), 64'(0));
      chk("b_in_ready_after", 64'(b_in_ready), 64'(1));

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
